// File: rtl/counter_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// counter_arbiter_pkg
// Shared types for the counter arbiter: the requester opcode encoding, the
// sequencer state encoding, and a helper that sizes requester index fields.
// ---------------------------------------------------------------------------
package counter_arbiter_pkg;

  typedef enum logic [1:0] {
    OP_INC   = 2'd0,
    OP_DEC   = 2'd1,
    OP_LOAD  = 2'd2,
    OP_CLEAR = 2'd3
  } op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH      = 16;
  localparam int DEFAULT_REQUESTERS = 4;

  // Width of a field holding an index in [0, n-1]; never narrower than 1 bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/counter_arbiter_if.sv
// ---------------------------------------------------------------------------
// counter_arbiter_if
// Bundles the requester handshake and the shared counter status.
//   req_valid  [R]     request pending, one bit per requester
//   req_op     [2R]    opcode of requester i in bits [2i+1:2i]
//   req_data   [W*R]   load value of requester i in bits [W*i+W-1:W*i]
//   req_ready  [R]     one-hot acceptance pulse
//   counter    [W]     current counter value
//   busy               high while an operation executes
//   grant_id   [IW]    index of last granted requester
//   wrapped            one-cycle pulse after an INC/DEC wrap
// master: requester side.  slave: arbiter side.
// ---------------------------------------------------------------------------
interface counter_arbiter_if #(
  parameter int WIDTH      = 16,
  parameter int REQUESTERS = 4
);
  localparam int IW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

  logic [REQUESTERS-1:0]       req_valid;
  logic [2*REQUESTERS-1:0]     req_op;
  logic [WIDTH*REQUESTERS-1:0] req_data;
  logic [REQUESTERS-1:0]       req_ready;
  logic [WIDTH-1:0]            counter;
  logic                        busy;
  logic [IW-1:0]               grant_id;
  logic                        wrapped;

  modport master (
    output req_valid, req_op, req_data,
    input  req_ready, counter, busy, grant_id, wrapped
  );

  modport slave (
    input  req_valid, req_op, req_data,
    output req_ready, counter, busy, grant_id, wrapped
  );

endinterface

// File: rtl/counter_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: returns the first set request bit at or
// after the pointer, wrapping past the top index back to 0.
//   req_i  [R]   request vector
//   ptr_i  [IW]  search start index (always < REQUESTERS)
//   any_o        at least one request set
//   idx_o  [IW]  chosen index (0 when any_o is low)
// ---------------------------------------------------------------------------
module rr_pick
  import counter_arbiter_pkg::*;
#(
  parameter  int REQUESTERS = DEFAULT_REQUESTERS,
  localparam int IW         = idx_width(REQUESTERS)
) (
  input  logic [REQUESTERS-1:0] req_i,
  input  logic [IW-1:0]         ptr_i,
  output logic                  any_o,
  output logic [IW-1:0]         idx_o
);

  int cand;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    any_o = |req_i;
    idx_o = '0;
    cand  = 0;
    // Walk offsets from farthest to nearest so the closest hit is assigned
    // last and wins.
    for (int off = REQUESTERS - 1; off >= 0; off--) begin
      cand = (int'(ptr_i) + off) % REQUESTERS;
      if (req_i[cand[IW-1:0]]) begin
        idx_o = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/counter_arbiter.sv
// ---------------------------------------------------------------------------
// counter_arbiter
// Shares one WIDTH-bit up/down/load counter between REQUESTERS requesters.
// A round-robin pick in IDLE latches the winner's opcode and data; EXEC
// pulses that requester's ready, applies the operation and advances the
// round-robin pointer past the winner.
//   clock       rising-edge clock
//   reset_      asynchronous active-low reset
//   bus         counter_arbiter_if slave: request handshake and status
// Outputs req_ready/busy decode registered state only; counter, grant_id
// and wrapped come straight from registers.
// ---------------------------------------------------------------------------
module counter_arbiter
  import counter_arbiter_pkg::*;
#(
  parameter  int WIDTH      = DEFAULT_WIDTH,
  parameter  int REQUESTERS = DEFAULT_REQUESTERS,
  localparam int IW         = idx_width(REQUESTERS)
) (
  input  logic              clock,
  input  logic              reset_,
  counter_arbiter_if.slave  bus
);

  state_t           state_q,   state_d;
  logic [IW-1:0]    ptr_q,     ptr_d;
  logic [IW-1:0]    grant_q,   grant_d;
  op_t              op_q,      op_d;
  logic [WIDTH-1:0] data_q,    data_d;
  logic [WIDTH-1:0] counter_q, counter_d;
  logic             wrapped_q, wrapped_d;

  logic             pick_any;
  logic [IW-1:0]    pick_idx;

  // Per-requester views of the packed opcode and data buses.
  logic [1:0]       op_a   [REQUESTERS];
  logic [WIDTH-1:0] data_a [REQUESTERS];

  for (genvar i = 0; i < REQUESTERS; i++) begin : g_unpack
    assign op_a[i]   = bus.req_op[2*i +: 2];
    assign data_a[i] = bus.req_data[WIDTH*i +: WIDTH];
  end

  rr_pick #(.REQUESTERS(REQUESTERS)) u_pick (
    .req_i (bus.req_valid),
    .ptr_i (ptr_q),
    .any_o (pick_any),
    .idx_o (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    op_d      = op_q;
    data_d    = data_q;
    counter_d = counter_q;
    wrapped_d = 1'b0;  // wrapped is a one-cycle pulse

    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          op_d    = op_t'(op_a[pick_idx]);
          data_d  = data_a[pick_idx];
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        unique case (op_q)
          OP_INC: begin
            counter_d = counter_q + WIDTH'(1);
            wrapped_d = &counter_q;
          end
          OP_DEC: begin
            counter_d = counter_q - WIDTH'(1);
            wrapped_d = ~|counter_q;
          end
          OP_LOAD:  counter_d = data_q;
          OP_CLEAR: counter_d = '0;
          default:  counter_d = counter_q;
        endcase
        ptr_d   = (grant_q == IW'(REQUESTERS - 1)) ? '0 : grant_q + IW'(1);
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      // NOTE: the latched opcode/data are reset too; they are a handful of
      // flops, not a memory, and a defined value keeps X out of simulation.
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      grant_q   <= '0;
      op_q      <= OP_INC;
      data_q    <= '0;
      counter_q <= '0;
      wrapped_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      op_q      <= op_d;
      data_q    <= data_d;
      counter_q <= counter_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign bus.busy      = (state_q == ST_EXEC);
  assign bus.req_ready = (state_q == ST_EXEC) ? (REQUESTERS'(1) << grant_q)
                                              : '0;
  assign bus.counter   = counter_q;
  assign bus.grant_id  = grant_q;
  assign bus.wrapped   = wrapped_q;

endmodule
